ble_usb_framer: RTL and testbench

//  Downstream stage of the BLE packet analyzer, feeding the USB output interface (data_o/valid_o/frame_o).
//  - Buffers one decoded BLE packet (payload bytes plus channel and RSSI).
//  - Emits it as a contiguous USB frame, one byte per clock: RSSI, channel, length, payload.
//  - Payload length is known only at end of packet, hence the single-packet buffer.

---
 rtl/ble_usb_framer.sv | 220 ++++++++++++++++++++++
 tb/tb_ble_usb_framer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_usb_framer.sv
// Single-packet BLE framer: buffers one packet, then emits RSSI, channel, length and payload one word per clock.
// Optional checksum word after the payload when BLE_USB_CHECKSUM_EN is defined.
module ble_usb_framer #(
  parameter int MAX_LEN = 64,
  parameter int DATA_W  = 8,
  parameter int CHAN_W  = 7,
  parameter int RSSI_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [CHAN_W-1:0] channel_i,
  input  logic [RSSI_W-1:0] rssi_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_DISCARD, S_HDR_RSSI, S_HDR_CHAN, S_HDR_LEN, S_PAYLOAD
`ifdef BLE_USB_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  // Handshake: a byte is taken on any edge where in_valid_i=1; there is no
  // backpressure, and valid_o=1 marks data_o as a frame word for that cycle.
  state_t              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          rd_idx_q, rd_idx_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [RSSI_W-1:0]   rssi_q, rssi_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_q, frame_d;
  logic                busy_q, busy_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                in_drop_q, in_drop_d;
  logic                drop_inc;
  logic                out_phase;
  logic                buf_we;
  logic [AW-1:0]       buf_widx;
  logic [DATA_W-1:0]   buf_q [0:DEPTH-1];
`ifdef BLE_USB_CHECKSUM_EN
  logic [DATA_W-1:0]   cks_q, cks_d;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    chan_d     = chan_q;
    rssi_d     = rssi_q;
    data_d     = '0;
    valid_d    = 1'b0;
    frame_d    = 1'b0;
    in_drop_d  = in_drop_q;
    drop_inc   = 1'b0;
    buf_we     = 1'b0;
    buf_widx   = len_q[AW-1:0];
    out_phase  = (state_q == S_HDR_RSSI) || (state_q == S_HDR_CHAN) ||
                 (state_q == S_HDR_LEN) || (state_q == S_PAYLOAD) ||
`ifdef BLE_USB_CHECKSUM_EN
                 (state_q == S_CKSUM) ||
`endif
                 ((state_q == S_IDLE) && busy_q);

    // A packet arriving while a frame is being emitted is swallowed whole,
    // possibly outliving the frame; it is counted once at its last byte.
    if (in_valid_i) begin
      if (in_drop_q) begin
        if (in_last_i) begin
          in_drop_d = 1'b0;
          drop_inc  = 1'b1;
        end
      end else if (out_phase) begin
        if (in_last_i) drop_inc  = 1'b1;
        else           in_drop_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !in_drop_q && !busy_q) begin
          buf_we   = 1'b1;
          buf_widx = '0;
          chan_d   = channel_i;
          rssi_d   = rssi_i;
          len_d    = 8'd1;
          state_d  = in_last_i ? S_HDR_RSSI : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid_i) begin
          if (len_q == 8'(MAX_LEN)) begin
            if (in_last_i) begin
              drop_inc = 1'b1;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_DISCARD;
            end
          end else begin
            buf_we = 1'b1;
            len_d  = len_q + 8'd1;
            if (in_last_i) state_d = S_HDR_RSSI;
          end
        end
      end
      S_DISCARD: begin
        if (in_valid_i && in_last_i) begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_HDR_RSSI: begin
        data_d  = DATA_W'(rssi_q);
        valid_d = 1'b1;
        frame_d = 1'b1;
        state_d = S_HDR_CHAN;
      end
      S_HDR_CHAN: begin
        data_d  = DATA_W'(chan_q);
        valid_d = 1'b1;
        frame_d = 1'b1;
        state_d = S_HDR_LEN;
      end
      S_HDR_LEN: begin
        data_d   = DATA_W'(len_q);
        valid_d  = 1'b1;
        frame_d  = 1'b1;
        rd_idx_d = 8'd0;
        state_d  = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        data_d   = buf_q[rd_idx_q[AW-1:0]];
        valid_d  = 1'b1;
        frame_d  = 1'b1;
        rd_idx_d = rd_idx_q + 8'd1;
        if (rd_idx_q == len_q - 8'd1) begin
`ifdef BLE_USB_CHECKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef BLE_USB_CHECKSUM_EN
      S_CKSUM: begin
        data_d  = cks_q;
        valid_d = 1'b1;
        frame_d = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef BLE_USB_CHECKSUM_EN
    cks_d = cks_q;
    if (state_q == S_HDR_RSSI)                  cks_d = data_d;
    else if (valid_d && (state_q != S_CKSUM))   cks_d = cks_q ^ data_d;
`endif

    // Busy stays high through the last word so the idle gap is visible on busy_o too.
    busy_d     = (state_d != S_IDLE) || valid_d;
    drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_idx_q   <= '0;
      chan_q     <= '0;
      rssi_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
      in_drop_q  <= 1'b0;
`ifdef BLE_USB_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      chan_q     <= chan_d;
      rssi_q     <= rssi_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
      in_drop_q  <= in_drop_d;
`ifdef BLE_USB_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) buf_q[buf_widx] <= in_data_i;
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign frame_o    = frame_q;
  assign busy_o     = busy_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ble_usb_framer.sv
// Directed bench for ble_usb_framer: framing, latency, overflow, busy drops, mid-frame reset, saturation.
module tb_ble_usb_framer;
  localparam int MAX_LEN = 64;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_last_i;
  logic [6:0] channel_i;
  logic [7:0] rssi_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_o;
  logic       busy_o;
  logic [7:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];

  ble_usb_framer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .channel_i  (channel_i),
    .rssi_i     (rssi_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_o    (frame_o),
    .busy_o     (busy_o),
    .drop_cnt_o (drop_cnt_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_data_i  = 8'($urandom_range(0, 255));
    channel_i  = 7'($urandom_range(0, 127));
    rssi_i     = 8'($urandom_range(0, 255));
  endtask

  task automatic send_pkt(input logic [6:0] ch, input logic [7:0] rssi);
    for (int i = 0; i < pay_q.size(); i++) begin
      in_valid_i = 1'b1;
      in_data_i  = pay_q[i];
      in_last_i  = (i == pay_q.size() - 1);
      channel_i  = (i == 0) ? ch : ~ch;
      rssi_i     = (i == 0) ? rssi : ~rssi;
      tick();
    end
    idle_inputs();
  endtask

  // scoreboard
  task automatic expect_frame(input logic [6:0] ch, input logic [7:0] rssi);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(rssi);
    exp_q.push_back({1'b0, ch});
    exp_q.push_back(8'(pay_q.size()));
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
`ifdef BLE_USB_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic check_frame(input int max_wait, input string name);
    int waited;
    int k;
    logic [7:0] e;
    waited = 0;
    k = 0;
    do begin
      tick();
      waited++;
    end while (valid_o !== 1'b1 && waited < max_wait);
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL %s start: valid_o=%b after %0d cycles, required 1", name, valid_o, waited);
      exp_q.delete();
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (data_o !== e || valid_o !== 1'b1 || frame_o !== 1'b1 || busy_o !== 1'b1) begin
          bad++;
          $display("FAIL %s word%0d: data_o=%h valid=%b frame=%b busy=%b, required data_o=%h valid=1 frame=1 busy=1",
                   name, k, data_o, valid_o, frame_o, busy_o, e);
        end
        k++;
        tick();
      end
      total++;
      if (valid_o !== 1'b0 || frame_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL %s gap: valid=%b frame=%b busy=%b, required 0 0 0", name, valid_o, frame_o, busy_o);
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      in_last_i  = 1'($urandom_range(0, 1));
      in_data_i  = 8'($urandom_range(0, 255));
      tick();
      total++;
      if (data_o !== 8'h00 || valid_o !== 1'b0 || frame_o !== 1'b0 || busy_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
        bad++;
        $display("FAIL reset_cycle%0d: data=%h valid=%b frame=%b busy=%b drop=%0d, required all 0",
                 c, data_o, valid_o, frame_o, busy_o, drop_cnt_o);
      end
    end
    idle_inputs();
    rst_i = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: valid=%b busy=%b drop=%0d, required 0 0 0", valid_o, busy_o, drop_cnt_o);
    end
  endtask

  task automatic test_basic();
    pay_q = '{8'hAA, 8'h55, 8'h0F};
    expect_frame(7'd37, 8'hC4);
    send_pkt(7'd37, 8'hC4);
    check_frame(1, "basic");
  endtask

  task automatic test_back_to_back();
    pay_q = '{8'h77};
    expect_frame(7'd1, 8'h10);
    send_pkt(7'd1, 8'h10);
    check_frame(1, "back_to_back");
  endtask

  task automatic test_overflow();
    int seen;
    pay_q.delete();
    for (int i = 0; i <= MAX_LEN; i++) pay_q.push_back(8'(i * 3 + 1));
    send_pkt(7'd9, 8'h44);
    total++;
    if (drop_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL overflow_drop: drop_cnt_o=%0d, required 1", drop_cnt_o);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_o === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL overflow_no_frame: valid_o cycles=%0d, required 0", seen);
    end
    pay_q = '{8'h3C};
    expect_frame(7'd127, 8'h01);
    send_pkt(7'd127, 8'h01);
    check_frame(1, "after_overflow");
  endtask

  task automatic test_busy_drop();
    logic [7:0] e;
    int k;
    int seen;
    pay_q = '{8'h11, 8'h22};
    expect_frame(7'd5, 8'h80);
    send_pkt(7'd5, 8'h80);
    k = 0;
    while (exp_q.size() > 0) begin
      if (k < 3) begin
        in_valid_i = 1'b1;
        in_data_i  = 8'(8'hE0 + k);
        in_last_i  = (k == 2);
        channel_i  = 7'd3;
        rssi_i     = 8'h66;
      end else begin
        idle_inputs();
      end
      tick();
      e = exp_q.pop_front();
      total++;
      if (data_o !== e || valid_o !== 1'b1 || frame_o !== 1'b1) begin
        bad++;
        $display("FAIL busy_frame word%0d: data_o=%h valid=%b frame=%b, required data_o=%h valid=1 frame=1",
                 k, data_o, valid_o, frame_o, e);
      end
      k++;
    end
    idle_inputs();
    tick();
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_gap: valid=%b busy=%b, required 0 0", valid_o, busy_o);
    end
    total++;
    if (drop_cnt_o !== 8'd2) begin
      bad++;
      $display("FAIL busy_drop_cnt: drop_cnt_o=%0d, required 2", drop_cnt_o);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid_o === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL busy_no_second_frame: valid_o cycles=%0d, required 0", seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    pay_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(7'd10, 8'h33);
    for (int c = 0; c < 5; c++) tick();
    total++;
    if (data_o !== 8'h02 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: data_o=%h valid=%b, required 02 1", data_o, valid_o);
    end
    rst_i = 1'b0;
    tick();
    total++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || frame_o !== 1'b0 || busy_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
      bad++;
      $display("FAIL midrst_out: data=%h valid=%b frame=%b busy=%b drop=%0d, required all 0",
               data_o, valid_o, frame_o, busy_o, drop_cnt_o);
    end
    rst_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (valid_o === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_no_resume: valid_o cycles=%0d, required 0", seen);
    end
    pay_q = '{8'hDE, 8'hAD};
    expect_frame(7'd20, 8'h99);
    send_pkt(7'd20, 8'h99);
    check_frame(1, "after_midrst");
  endtask

  task automatic test_saturate();
    pay_q = '{8'h5A};
    expect_frame(7'd0, 8'hFF);
    send_pkt(7'd0, 8'hFF);
    check_frame(1, "single_byte");
    pay_q.delete();
    for (int i = 0; i <= MAX_LEN; i++) pay_q.push_back(8'(i));
    for (int p = 0; p < 300; p++) begin
      send_pkt(7'd2, 8'h20);
      if (p == 253) begin
        total++;
        if (drop_cnt_o !== 8'd254) begin
          bad++;
          $display("FAIL sat_254: drop_cnt_o=%0d, required 254", drop_cnt_o);
        end
      end
    end
    total++;
    if (drop_cnt_o !== 8'd255) begin
      bad++;
      $display("FAIL sat_hold: drop_cnt_o=%0d, required 255", drop_cnt_o);
    end
  endtask

  // sequence and report
  initial begin
    rst_i = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_busy_drop();
    test_reset_mid_frame();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
